mem_bus_arbiter: RTL and testbench

- Shares the single external CPU memory bus (ADDR, Data_BUS_WRITE, Data_BUS_READ, CS, WR_RD) between two requesters: port 0 is instruction fetch and port 1 is data load/store.
- Sits between the cpu core pipeline and the top-level memory pins, and sequences each access with a configurable number of wait states.
- Two-way round-robin arbitration; one transaction in flight at a time.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared constants and types for the CPU memory-bus arbiter: state encoding,
// bus direction values, default widths and the wait-counter width helper.
package cpu_bus_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } state_t;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  // WAIT_CYCLES=0 would give a zero-width counter, so clamp to one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win
// last time is chosen. No state, zero latency, no backpressure of its own.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_any_req
);

  always_comb begin
    o_any_req = |i_req;
    o_winner  = 1'b0;
    if (i_req == 2'b11) o_winner = ~i_last;
    else if (i_req[1])  o_winner = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between fetch (port 0) and load/store (port 1).
// Grant at edge k, CS high WAIT_CYCLES+1 cycles, done one cycle later; requesters wait holding req.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_BUS_WRITE,
  input  logic [DATA_W-1:0] Data_BUS_READ,
  output logic              CS,
  output logic              WR_RD,
  output logic              busy,
  output logic              gnt_id
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_last, w_last_nxt;
  logic               r_gnt, w_gnt_nxt;
  logic               r_cs, w_cs_nxt;
  logic               r_wr, w_wr_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
  logic [1:0]         r_done, w_done_nxt;
  logic [DATA_W-1:0]  r_rdata0, w_rdata0_nxt;
  logic [DATA_W-1:0]  r_rdata1, w_rdata1_nxt;
  logic               r_busy;
  logic               w_winner, w_any_req;

  rr_arbiter2 u_rr (
    .i_req     ({m1_req, m0_req}),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_gnt_nxt    = r_gnt;
    w_cs_nxt     = r_cs;
    w_wr_nxt     = r_wr;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_done_nxt   = 2'b00;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = CNT_INIT;
          w_last_nxt  = w_winner;
          w_gnt_nxt   = w_winner;
          w_cs_nxt    = 1'b1;
          w_wr_nxt    = w_winner ? m1_wr    : m0_wr;
          w_addr_nxt  = w_winner ? m1_addr  : m0_addr;
          w_wdata_nxt = w_winner ? m1_wdata : m0_wdata;
        end
      end
      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          if (r_wr == BUS_RD) begin
            if (r_gnt) w_rdata1_nxt = Data_BUS_READ;
            else       w_rdata0_nxt = Data_BUS_READ;
          end
          // Bus returns to all-zero the moment CS drops.
          w_cs_nxt          = 1'b0;
          w_wr_nxt          = 1'b0;
          w_addr_nxt        = '0;
          w_wdata_nxt       = '0;
          w_done_nxt[r_gnt] = 1'b1;
          w_state_nxt       = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cs_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_cs     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_done   <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      r_gnt    <= w_gnt_nxt;
      r_cs     <= w_cs_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_done   <= w_done_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign ADDR           = r_addr;
  assign Data_BUS_WRITE = r_wdata;
  assign CS             = r_cs;
  assign WR_RD          = r_wr;
  assign m0_done        = r_done[0];
  assign m1_done        = r_done[1];
  assign m0_rdata       = r_rdata0;
  assign m1_rdata       = r_rdata1;
  assign busy           = r_busy;
  assign gnt_id         = r_gnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with WAIT_CYCLES=1: reset, read, write,
// contention, late input changes and reset mid-access.
module tb_mem_bus_arbiter;

  logic        CLK = 1'b0;
  logic        Rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ADDR, Data_BUS_WRITE, Data_BUS_READ;
  logic        CS, WR_RD, busy, gnt_id;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
    .CLK(CLK), .Rst(Rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata),
    .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
    .CS(CS), .WR_RD(WR_RD), .busy(busy), .gnt_id(gnt_id)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h40; Data_BUS_READ = 32'h1DAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (CS !== 1'b0) begin tests_failed++; $display("FAIL rst_cs cyc=%0d got=%0h exp=0", i, CS); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy cyc=%0d got=%0h exp=0", i, busy); end
      tests_run++; if (ADDR !== 32'h0) begin tests_failed++; $display("FAIL rst_addr cyc=%0d got=%0h exp=0", i, ADDR); end
      tests_run++; if (m0_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done cyc=%0d got=%0h exp=0", i, m0_done); end
    end
    Rst = 1'b0;
    tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL rst_first_grant_cs got=%0h exp=1", CS); end
    tests_run++; if (gnt_id !== 1'b0) begin tests_failed++; $display("FAIL rst_first_grant_id got=%0h exp=0", gnt_id); end
    tick(); tick();
    m0_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h0000_0040; Data_BUS_READ = 32'h1DAA;
    tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL rd_cs1 got=%0h exp=1", CS); end
    tests_run++; if (ADDR !== 32'h40) begin tests_failed++; $display("FAIL rd_addr1 got=%0h exp=40", ADDR); end
    tests_run++; if (WR_RD !== 1'b0) begin tests_failed++; $display("FAIL rd_wrrd got=%0h exp=0", WR_RD); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy got=%0h exp=1", busy); end
    tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL rd_cs2 got=%0h exp=1", CS); end
    tests_run++; if (ADDR !== 32'h40) begin tests_failed++; $display("FAIL rd_addr2 got=%0h exp=40", ADDR); end
    tests_run++; if (m0_done !== 1'b0) begin tests_failed++; $display("FAIL rd_early_done got=%0h exp=0", m0_done); end
    tick();
    tests_run++; if (CS !== 1'b0) begin tests_failed++; $display("FAIL rd_cs_end got=%0h exp=0", CS); end
    tests_run++; if (ADDR !== 32'h0) begin tests_failed++; $display("FAIL rd_addr_end got=%0h exp=0", ADDR); end
    tests_run++; if (m0_done !== 1'b1) begin tests_failed++; $display("FAIL rd_done got=%0h exp=1", m0_done); end
    tests_run++; if (m0_rdata !== 32'h1DAA) begin tests_failed++; $display("FAIL rd_rdata got=%0h exp=1daa", m0_rdata); end
    tests_run++; if (m1_done !== 1'b0) begin tests_failed++; $display("FAIL rd_m1_done got=%0h exp=0", m1_done); end
    m0_req = 1'b0;
    tick();
    tests_run++; if (m0_done !== 1'b0) begin tests_failed++; $display("FAIL rd_done_clear got=%0h exp=0", m0_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rd_idle_busy got=%0h exp=0", busy); end
    tick();
    tests_run++; if (CS !== 1'b0) begin tests_failed++; $display("FAIL rd_no_regrant got=%0h exp=0", CS); end
  endtask

  task automatic test_single_write();
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hDEADBEEF; Data_BUS_READ = 32'h5555_5555;
    tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL wr_cs1 got=%0h exp=1", CS); end
    tests_run++; if (WR_RD !== 1'b1) begin tests_failed++; $display("FAIL wr_wrrd got=%0h exp=1", WR_RD); end
    tests_run++; if (Data_BUS_WRITE !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_wdata got=%0h exp=deadbeef", Data_BUS_WRITE); end
    tests_run++; if (ADDR !== 32'h100) begin tests_failed++; $display("FAIL wr_addr got=%0h exp=100", ADDR); end
    tests_run++; if (gnt_id !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt got=%0h exp=1", gnt_id); end
    tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL wr_cs2 got=%0h exp=1", CS); end
    tick();
    tests_run++; if (CS !== 1'b0) begin tests_failed++; $display("FAIL wr_cs_end got=%0h exp=0", CS); end
    tests_run++; if (Data_BUS_WRITE !== 32'h0) begin tests_failed++; $display("FAIL wr_wdata_end got=%0h exp=0", Data_BUS_WRITE); end
    tests_run++; if (m1_done !== 1'b1) begin tests_failed++; $display("FAIL wr_done got=%0h exp=1", m1_done); end
    tests_run++; if (m0_done !== 1'b0) begin tests_failed++; $display("FAIL wr_m0_done got=%0h exp=0", m0_done); end
    tests_run++; if (m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rdata_kept got=%0h exp=0", m1_rdata); end
    m1_req = 1'b0; m1_wr = 1'b0;
    tick(); tick();
  endtask

  task automatic test_contention();
    logic        exp_id;
    logic [31:0] exp_rd;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      exp_rd = 32'hA000 + i;
      Data_BUS_READ = exp_rd;
      tick();
      tests_run++; if (gnt_id !== exp_id || CS !== 1'b1) begin tests_failed++; $display("FAIL cont_grant txn=%0d got id=%0h cs=%0h exp id=%0h cs=1", i, gnt_id, CS, exp_id); end
      tests_run++; if (ADDR !== (exp_id ? 32'h20 : 32'h10)) begin tests_failed++; $display("FAIL cont_addr txn=%0d got=%0h exp=%0h", i, ADDR, exp_id ? 32'h20 : 32'h10); end
      tick(); tick();
      tests_run++; if ({m1_done, m0_done} !== (exp_id ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL cont_done txn=%0d got=%0b exp=%0b", i, {m1_done, m0_done}, exp_id ? 2'b10 : 2'b01); end
      tests_run++; if ((exp_id ? m1_rdata : m0_rdata) !== exp_rd) begin tests_failed++; $display("FAIL cont_rdata txn=%0d got=%0h exp=%0h", i, exp_id ? m1_rdata : m0_rdata, exp_rd); end
      tick();
      tests_run++; if ({m1_done, m0_done, busy, CS} !== 4'b0000) begin tests_failed++; $display("FAIL cont_gap txn=%0d got=%0b exp=0000", i, {m1_done, m0_done, busy, CS}); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cont_final_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_drop_late();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h200; Data_BUS_READ = 32'h7777;
    tick();
    tests_run++; if (ADDR !== 32'h200) begin tests_failed++; $display("FAIL drop_addr_grant got=%0h exp=200", ADDR); end
    m0_req = 1'b0; m0_addr = 32'hFFFF;
    tick();
    tests_run++; if (ADDR !== 32'h200 || CS !== 1'b1) begin tests_failed++; $display("FAIL drop_addr_held got addr=%0h cs=%0h exp addr=200 cs=1", ADDR, CS); end
    tick();
    tests_run++; if (m0_done !== 1'b1) begin tests_failed++; $display("FAIL drop_done got=%0h exp=1", m0_done); end
    tests_run++; if (m0_rdata !== 32'h7777) begin tests_failed++; $display("FAIL drop_rdata got=%0h exp=7777", m0_rdata); end
    tick();
    tests_run++; if (m0_done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL drop_idle got done=%0h busy=%0h exp 0 0", m0_done, busy); end
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h300; Data_BUS_READ = 32'h9999;
    tick();
    tests_run++; if (CS !== 1'b1 || gnt_id !== 1'b1) begin tests_failed++; $display("FAIL rmid_grant got cs=%0h id=%0h exp 1 1", CS, gnt_id); end
    tick();
    Rst = 1'b1;
    tick();
    tests_run++; if (CS !== 1'b0) begin tests_failed++; $display("FAIL rmid_cs got=%0h exp=0", CS); end
    tests_run++; if (m1_done !== 1'b0) begin tests_failed++; $display("FAIL rmid_done got=%0h exp=0", m1_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got=%0h exp=0", busy); end
    tests_run++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin tests_failed++; $display("FAIL rmid_rdata got m0=%0h m1=%0h exp 0 0", m0_rdata, m1_rdata); end
    Rst = 1'b0; m1_req = 1'b0;
    tick();
    tests_run++; if (m1_done !== 1'b0 || CS !== 1'b0) begin tests_failed++; $display("FAIL rmid_after got done=%0h cs=%0h exp 0 0", m1_done, CS); end
  endtask

  initial begin
    Rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    Data_BUS_READ = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_drop_late();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
